// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spi_pkg
//  Purpose  : Shared FSM encoding and frame-width helper for the SPI regbank.
//  Revision : 1.0 - initial release
// ============================================================================
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_WDATA = 3'd2,
        ST_RDATA = 3'd3,
        ST_DONE  = 3'd4
    } spi_state_t;

    function automatic int frame_w(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module   : spi_sync_edge
//  Purpose  : Multi-flop synchronizer with a history flop for edge detection.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] r_chain;
    logic                   r_hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chain <= {SYNC_STAGES{RESET_VAL}};
            r_hist  <= RESET_VAL;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], din};
            r_hist  <= r_chain[SYNC_STAGES-1];
        end
    end

    assign sync = r_chain[SYNC_STAGES-1];
    assign rise = r_chain[SYNC_STAGES-1] & ~r_hist;
    assign fall = ~r_chain[SYNC_STAGES-1] & r_hist;

endmodule
`default_nettype wire

// File: rtl/spi_regbank.sv
`default_nettype none
// ============================================================================
//  Module   : spi_regbank
//  Purpose  : SPI (mode 0) slave giving read/write access to a register bank.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_regbank
    import spi_pkg::*;
#(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int NUM_REGS    = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       SCLK,
    input  logic                       nCS,
    input  logic                       COPI,
    output logic                       CIPO,
    output logic                       CIPO_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic                       wr_pulse,
    output logic [ADDR_W-1:0]          wr_addr
);

    localparam int c_FRAME_W = frame_w(ADDR_W, DATA_W);
    localparam int c_HDR_W   = 1 + ADDR_W;
    localparam int c_CNT_W   = $clog2(c_FRAME_W + 1);
    localparam int c_SH_W    = (ADDR_W > DATA_W - 1) ? ADDR_W : DATA_W - 1;
    localparam int c_SETTLE  = SYNC_STAGES + 1;
    localparam int c_SET_W   = $clog2(c_SETTLE + 1);

    logic w_sclk_sync, w_sclk_rise, w_sclk_fall;
    logic w_ncs_sync,  w_ncs_rise,  w_ncs_fall;
    logic w_copi,      w_copi_rise, w_copi_fall;
    logic w_unused;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .din(SCLK),
        .sync(w_sclk_sync), .rise(w_sclk_rise), .fall(w_sclk_fall));
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
        .clk(clk), .rst_n(rst_n), .din(nCS),
        .sync(w_ncs_sync), .rise(w_ncs_rise), .fall(w_ncs_fall));
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
        .clk(clk), .rst_n(rst_n), .din(COPI),
        .sync(w_copi), .rise(w_copi_rise), .fall(w_copi_fall));

    assign w_unused = ^{w_sclk_sync, w_ncs_rise, w_copi_rise, w_copi_fall};

    spi_state_t                r_state;
    logic [c_CNT_W-1:0]        r_cnt;
    logic [c_SH_W-1:0]         r_shift;
    logic [ADDR_W-1:0]         r_addr;
    logic [DATA_W-1:0]         r_snap;
    logic                      r_cipo, r_cipo_oe, r_wr_pulse;
    logic [ADDR_W-1:0]         r_wr_addr;
    logic [NUM_REGS*DATA_W-1:0] r_regs;
    logic [c_SET_W-1:0]        r_settle;
    logic                      r_armed;

    logic                      w_hdr_rw;
    logic [ADDR_W-1:0]         w_hdr_addr;
    logic [DATA_W-1:0]         w_wr_data;
    logic [DATA_W-1:0]         w_rd_val;

    assign w_hdr_rw   = r_shift[ADDR_W-1];
    assign w_hdr_addr = {r_shift[ADDR_W-2:0], w_copi};
    assign w_wr_data  = {r_shift[DATA_W-2:0], w_copi};

    always_comb begin
        w_rd_val = '0;
        if (int'(w_hdr_addr) < NUM_REGS)
            w_rd_val = r_regs[int'(w_hdr_addr)*DATA_W +: DATA_W];
    end

    // Frames are accepted only after the nCS synchronizer has flushed its reset
    // value and shown a real high level, so a frame needs a fresh falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_settle <= '0;
            r_armed  <= 1'b0;
        end else begin
            if (r_settle != c_SET_W'(c_SETTLE))
                r_settle <= r_settle + 1'b1;
            if (r_settle == c_SET_W'(c_SETTLE) && w_ncs_sync)
                r_armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_shift    <= '0;
            r_addr     <= '0;
            r_snap     <= '0;
            r_cipo     <= 1'b0;
            r_cipo_oe  <= 1'b0;
            r_wr_pulse <= 1'b0;
            r_wr_addr  <= '0;
            r_regs     <= '0;
        end else begin
            r_wr_pulse <= 1'b0;
            if (w_ncs_sync) begin
                r_state   <= ST_IDLE;
                r_cipo    <= 1'b0;
                r_cipo_oe <= 1'b0;
            end else if (w_ncs_fall && r_armed) begin
                r_state   <= ST_ADDR;
                r_cnt     <= '0;
                r_shift   <= '0;
                r_cipo    <= 1'b0;
                r_cipo_oe <= 1'b0;
            end else begin
                case (r_state)
                    ST_ADDR: if (w_sclk_rise) begin
                        r_shift <= {r_shift[c_SH_W-2:0], w_copi};
                        r_cnt   <= r_cnt + 1'b1;
                        if (r_cnt == c_CNT_W'(c_HDR_W - 1)) begin
                            r_addr <= w_hdr_addr;
                            if (w_hdr_rw) begin
                                r_state <= ST_WDATA;
                            end else begin
                                r_state   <= ST_RDATA;
                                r_cipo_oe <= 1'b1;
                                r_cipo    <= w_rd_val[DATA_W-1];
                                r_snap    <= w_rd_val << 1;
                            end
                        end
                    end
                    ST_WDATA: if (w_sclk_rise) begin
                        r_shift <= {r_shift[c_SH_W-2:0], w_copi};
                        r_cnt   <= r_cnt + 1'b1;
                        if (r_cnt == c_CNT_W'(c_FRAME_W - 1)) begin
                            r_state <= ST_DONE;
                            if (int'(r_addr) < NUM_REGS) begin
                                r_regs[int'(r_addr)*DATA_W +: DATA_W] <= w_wr_data;
                                r_wr_pulse <= 1'b1;
                                r_wr_addr  <= r_addr;
                            end
                        end
                    end
                    // The falling edge that closes the last address bit is not a
                    // data-phase edge; only falls after a data-phase rise shift.
                    ST_RDATA: begin
                        if (w_sclk_rise && r_cnt < c_CNT_W'(c_FRAME_W))
                            r_cnt <= r_cnt + 1'b1;
                        if (w_sclk_fall && r_cnt > c_CNT_W'(c_HDR_W)) begin
                            if (r_cnt == c_CNT_W'(c_FRAME_W)) begin
                                r_state   <= ST_DONE;
                                r_cipo    <= 1'b0;
                                r_cipo_oe <= 1'b0;
                            end else begin
                                r_cipo <= r_snap[DATA_W-1];
                                r_snap <= r_snap << 1;
                            end
                        end
                    end
                    ST_IDLE, ST_DONE: ;
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign CIPO      = r_cipo;
    assign CIPO_oe   = r_cipo_oe;
    assign regs_flat = r_regs;
    assign wr_pulse  = r_wr_pulse;
    assign wr_addr   = r_wr_addr;

endmodule
`default_nettype wire

// File: tb/tb_spi_regbank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_regbank
//  Purpose  : Self-checking bench for spi_regbank (default and wide variants).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_regbank;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        SCLK = 1'b0;
    logic        COPI = 1'b0;
    logic        ncs_a = 1'b1;
    logic        ncs_b = 1'b1;
    logic        cipo_a, oe_a, wr_pulse_a;
    logic        cipo_b, oe_b, wr_pulse_b;
    logic [39:0] regs_flat_a;
    logic [47:0] regs_flat_b;
    logic [6:0]  wr_addr_a;
    logic [3:0]  wr_addr_b;

    always #5 clk = ~clk;

    spi_regbank dut_a (
        .clk(clk), .rst_n(rst_n), .SCLK(SCLK), .nCS(ncs_a), .COPI(COPI),
        .CIPO(cipo_a), .CIPO_oe(oe_a), .regs_flat(regs_flat_a),
        .wr_pulse(wr_pulse_a), .wr_addr(wr_addr_a));

    spi_regbank #(.ADDR_W(4), .DATA_W(16), .NUM_REGS(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .SCLK(SCLK), .nCS(ncs_b), .COPI(COPI),
        .CIPO(cipo_b), .CIPO_oe(oe_b), .regs_flat(regs_flat_b),
        .wr_pulse(wr_pulse_b), .wr_addr(wr_addr_b));

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Reference model: plain register arrays plus expected side effects.
    logic [7:0]  model_a [5];
    logic [15:0] model_b [3];
    int          exp_pulses_a = 0;
    int          exp_pulses_b = 0;
    logic [6:0]  exp_wr_addr_a = '0;

    int   pulses_a = 0, pulses_b = 0, long_pulses = 0;
    logic prev_a = 1'b0, prev_b = 1'b0;

    always @(posedge clk) begin
        prev_a <= wr_pulse_a;
        prev_b <= wr_pulse_b;
        if (wr_pulse_a) pulses_a <= pulses_a + 1;
        if (wr_pulse_b) pulses_b <= pulses_b + 1;
        if ((wr_pulse_a && prev_a) || (wr_pulse_b && prev_b)) long_pulses <= long_pulses + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [39:0] flat_a();
        logic [39:0] f;
        for (int i = 0; i < 5; i++) f[i*8 +: 8] = model_a[i];
        return f;
    endfunction

    function automatic logic [7:0] exp_rd_a(input int addr);
        return (addr < 5) ? model_a[addr] : 8'h00;
    endfunction

    function automatic void model_write_a(input int addr, input logic [7:0] data);
        if (addr < 5) begin
            model_a[addr] = data;
            exp_pulses_a++;
            exp_wr_addr_a = 7'(addr);
        end
    endfunction

    // One SPI transaction: frame bits MSB first, then random filler for any
    // extra pulses. CIPO is sampled at each SCLK rise, as a mode-0 master would.
    task automatic spi_xfer(input bit sel_b, input logic [31:0] frame, input int fw,
                            input int npulses, input bit hold_cs,
                            output logic [31:0] rd, output int oe_bits, output int bad_cipo);
        logic c_oe, c_cipo;
        rd = '0; oe_bits = 0; bad_cipo = 0;
        @(negedge clk);
        if (sel_b) ncs_b = 1'b0; else ncs_a = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < npulses; i++) begin
            COPI = (i < fw) ? frame[fw-1-i] : 1'($urandom);
            repeat (4) @(negedge clk);
            SCLK = 1'b1;
            c_oe   = sel_b ? oe_b : oe_a;
            c_cipo = sel_b ? cipo_b : cipo_a;
            if (c_oe) begin
                rd = {rd[30:0], c_cipo};
                oe_bits++;
            end else if (c_cipo) begin
                bad_cipo++;
            end
            repeat (4) @(negedge clk);
            SCLK = 1'b0;
        end
        repeat (6) @(negedge clk);
        if (!hold_cs) begin
            ncs_a = 1'b1;
            ncs_b = 1'b1;
        end
        repeat (6) @(negedge clk);
    endtask

    initial begin
        logic [31:0] rd;
        int          oeb, bad, addr;
        logic [7:0]  data;
        bit          rw;

        for (int i = 0; i < 5; i++) model_a[i] = '0;
        for (int i = 0; i < 3; i++) model_b[i] = '0;

        repeat (4) @(negedge clk);
        check("reset_regs",     64'(regs_flat_a), 64'h0);
        check("reset_wr_pulse", 64'(wr_pulse_a),  64'h0);
        check("reset_wr_addr",  64'(wr_addr_a),   64'h0);
        check("reset_cipo_oe",  64'({cipo_a, oe_a}), 64'h0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Write 0xA5 to addr 0.
        spi_xfer(0, 32'h80A5, 16, 16, 0, rd, oeb, bad);
        model_write_a(0, 8'hA5);
        check("wr0_regs",   64'(regs_flat_a), 64'(flat_a()));
        check("wr0_pulses", 64'(pulses_a),    64'(exp_pulses_a));
        check("wr0_addr",   64'(wr_addr_a),   64'(exp_wr_addr_a));

        // Write addr 4 then read it back.
        spi_xfer(0, 32'h843C, 16, 16, 0, rd, oeb, bad);
        model_write_a(4, 8'h3C);
        check("wr4_regs", 64'(regs_flat_a), 64'(flat_a()));
        spi_xfer(0, {16'h0, 8'h04, 8'($urandom)}, 16, 16, 0, rd, oeb, bad);
        check("rd4_data",    64'(rd[7:0]), 64'(exp_rd_a(4)));
        check("rd4_oe_bits", 64'(oeb),     64'd8);
        check("rd4_cipo_idle", 64'(bad),   64'd0);

        // Unimplemented address 0x30.
        spi_xfer(0, 32'hB0FF, 16, 16, 0, rd, oeb, bad);
        model_write_a(8'h30, 8'hFF);
        check("wr30_regs",   64'(regs_flat_a), 64'(flat_a()));
        check("wr30_pulses", 64'(pulses_a),    64'(exp_pulses_a));
        check("wr30_addr",   64'(wr_addr_a),   64'(exp_wr_addr_a));
        spi_xfer(0, 32'h3000, 16, 16, 0, rd, oeb, bad);
        check("rd30_data", 64'(rd[7:0]), 64'h00);
        check("rd30_oe",   64'(oeb),     64'd8);

        // Aborted write after 10 bits, then full write to addr 1.
        spi_xfer(0, 32'h81C3, 16, 10, 0, rd, oeb, bad);
        check("abort_regs",   64'(regs_flat_a), 64'(flat_a()));
        check("abort_pulses", 64'(pulses_a),    64'(exp_pulses_a));
        spi_xfer(0, 32'h815A, 16, 16, 0, rd, oeb, bad);
        model_write_a(1, 8'h5A);
        check("wr1_regs",   64'(regs_flat_a), 64'(flat_a()));
        check("wr1_pulses", 64'(pulses_a),    64'(exp_pulses_a));

        // Over-long frame: 20 pulses, exactly one commit.
        spi_xfer(0, 32'h8211, 16, 20, 0, rd, oeb, bad);
        model_write_a(2, 8'h11);
        check("long_regs",   64'(regs_flat_a), 64'(flat_a()));
        check("long_pulses", 64'(pulses_a),    64'(exp_pulses_a));

        // Randomized traffic against the model.
        for (int k = 0; k < 12; k++) begin
            addr = int'($urandom_range(0, 7));
            data = 8'($urandom);
            rw   = 1'($urandom);
            spi_xfer(0, {16'h0, rw, 7'(addr), data}, 16, 16, 0, rd, oeb, bad);
            if (rw) begin
                model_write_a(addr, data);
                check("rnd_wr_regs",   64'(regs_flat_a), 64'(flat_a()));
                check("rnd_wr_pulses", 64'(pulses_a),    64'(exp_pulses_a));
                check("rnd_wr_addr",   64'(wr_addr_a),   64'(exp_wr_addr_a));
            end else begin
                check("rnd_rd_data", 64'(rd[7:0]), 64'(exp_rd_a(addr)));
                check("rnd_rd_oe",   64'(oeb),     64'd8);
            end
            check("rnd_cipo_idle", 64'(bad), 64'd0);
        end

        // Reset mid-frame: no commit, everything back to zero.
        spi_xfer(0, 32'h8399, 16, 12, 1, rd, oeb, bad);
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) model_a[i] = '0;
        exp_wr_addr_a = '0;
        repeat (3) @(negedge clk);
        check("midrst_regs", 64'(regs_flat_a), 64'h0);
        check("midrst_addr", 64'(wr_addr_a),   64'h0);
        check("midrst_oe",   64'({cipo_a, oe_a}), 64'h0);
        ncs_a = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("postrst_pulses", 64'(pulses_a), 64'(exp_pulses_a));
        spi_xfer(0, 32'h8377, 16, 16, 0, rd, oeb, bad);
        model_write_a(3, 8'h77);
        check("postrst_regs", 64'(regs_flat_a), 64'(flat_a()));

        // Wide variant: 4-bit address, 16-bit data, 3 registers.
        spi_xfer(1, {11'h0, 1'b1, 4'd1, 16'hBEEF}, 21, 21, 0, rd, oeb, bad);
        model_b[1] = 16'hBEEF;
        exp_pulses_b++;
        check("b_wr_regs",   64'(regs_flat_b), 64'({model_b[2], model_b[1], model_b[0]}));
        check("b_wr_pulses", 64'(pulses_b),    64'(exp_pulses_b));
        check("b_wr_addr",   64'(wr_addr_b),   64'd1);
        spi_xfer(1, {11'h0, 1'b0, 4'd1, 16'h0}, 21, 21, 0, rd, oeb, bad);
        check("b_rd_data", 64'(rd[15:0]), 64'(model_b[1]));
        check("b_rd_oe",   64'(oeb),      64'd16);
        spi_xfer(1, {11'h0, 1'b1, 4'd5, 16'h1234}, 21, 21, 0, rd, oeb, bad);
        check("b_oob_regs",   64'(regs_flat_b), 64'({model_b[2], model_b[1], model_b[0]}));
        check("b_oob_pulses", 64'(pulses_b),    64'(exp_pulses_b));

        // dut_a saw SCLK toggling with its nCS high throughout the wide frames.
        check("a_idle_regs",  64'(regs_flat_a), 64'(flat_a()));
        check("single_cycle_pulses", 64'(long_pulses), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
